// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the decode stage of the 5-stage MIPS pipeline.
//
// Contents:
//   instr_width, adddr_width  - instruction and address widths
//   Instr                     - instruction word type
//   OP_*                      - primary opcodes the decoder distinguishes
//   BAD_INSTR                 - fetch-side marker for "no valid instruction"
//   if_id_t                   - IF/ID pipeline register
//   id_ex_t                   - ID/EX pipeline register
//   is_alu_imm / uses_rt / writes_reg - opcode classification helpers
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int unsigned instr_width = 32;
    localparam int unsigned adddr_width = 32;

    typedef logic [instr_width-1:0] Instr;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam Instr BAD_INSTR = 32'hFEED_DEAD;

    typedef struct packed {
        Instr                   instr;
        logic [adddr_width-1:0] pc_plus_4;
        logic                   valid;
    } if_id_t;

    typedef struct packed {
        logic                   valid;
        logic [5:0]             opcode;
        logic [31:0]            rs_val;
        logic [31:0]            rt_val;
        logic [31:0]            imm;
        logic [4:0]             dest;
        logic                   reg_write;
        logic                   is_load;
        logic [adddr_width-1:0] pc_plus_4;
    } id_ex_t;

    // ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI occupy 6'b001xxx.
    function automatic logic is_alu_imm(input logic [5:0] op);
        return op[5:3] == 3'b001;
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic writes_reg(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || is_alu_imm(op);
    endfunction

endpackage

// File: rtl/instr_decode_if.sv
// -----------------------------------------------------------------------------
// instr_decode_if
// Signal bundle between the decode stage and its neighbours (fetch, EX, WB).
//
// Signals:
//   if_instr, if_pc_plus_4       - instruction and PC+4 from fetch
//   flush                        - branch taken in EX, kill younger instructions
//   wb_en, wb_addr, wb_data      - register-file write port from writeback
//   stall                        - hold fetch PC and IF/ID this cycle
//   id_*                         - ID/EX register outputs
//
// Modports:
//   slave  - the decode stage (consumes if_*/flush/wb_*, drives stall/id_*)
//   master - the surrounding pipeline (drives if_*/flush/wb_*)
// -----------------------------------------------------------------------------
interface instr_decode_if;
    import mips_pkg::*;

    Instr                   if_instr;
    logic [adddr_width-1:0] if_pc_plus_4;
    logic                   flush;
    logic                   wb_en;
    logic [4:0]             wb_addr;
    logic [31:0]            wb_data;

    logic                   stall;
    logic                   id_valid;
    logic [5:0]             id_opcode;
    logic [31:0]            id_rs_val;
    logic [31:0]            id_rt_val;
    logic [31:0]            id_imm;
    logic [4:0]             id_dest;
    logic                   id_reg_write;
    logic                   id_is_load;
    logic [adddr_width-1:0] id_pc_plus_4;

    modport slave (
        input  if_instr, if_pc_plus_4, flush, wb_en, wb_addr, wb_data,
        output stall, id_valid, id_opcode, id_rs_val, id_rt_val, id_imm, id_dest,
               id_reg_write, id_is_load, id_pc_plus_4
    );

    modport master (
        output if_instr, if_pc_plus_4, flush, wb_en, wb_addr, wb_data,
        input  stall, id_valid, id_opcode, id_rs_val, id_rt_val, id_imm, id_dest,
               id_reg_write, id_is_load, id_pc_plus_4
    );

endinterface

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 32 x 32-bit register file, two asynchronous read ports, one synchronous
// write port. Register 0 always reads 0 and ignores writes. Synchronous
// active-low reset clears every entry.
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   - a read of the address being written this cycle returns wdata_i
//   undefined - reads return the stored (pre-write) value
//
// Ports:
//   clk, reset             - clock, synchronous active-low reset
//   we_i, waddr_i, wdata_i - write port
//   raddr_a_i, rdata_a_o   - read port A
//   raddr_b_i, rdata_b_o   - read port B
// -----------------------------------------------------------------------------
module reg_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    output logic [31:0] rdata_a_o,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_b_o
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_live;

    assign wr_live = we_i && (waddr_i != 5'd0);

    always_comb begin : next_regs
        regs_d = regs_q;
        if (wr_live) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin : regs_ff
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin : read_ports
        rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i];
        rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i];
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight write so WB and ID can share a cycle.
        if (wr_live && (waddr_i == raddr_a_i)) begin
            rdata_a_o = wdata_i;
        end
        if (wr_live && (waddr_i == raddr_b_i)) begin
            rdata_b_o = wdata_i;
        end
`else
`endif
    end

endmodule

// File: rtl/instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Decode stage of the MIPS pipeline: IF/ID register, field decode, register
// file read, load-use hazard detection and the ID/EX register.
//
// Configuration macro: REGFILE_BYPASS_EN (passed through to reg_file)
//
// Ports:
//   clk   - pipeline clock, rising edge
//   reset - synchronous active-low reset; clears IF/ID, ID/EX and the regfile
//   bus   - instr_decode_if.slave: fetch inputs, flush, writeback port,
//           stall output and the id_* ID/EX outputs
//
// Priority at each edge: reset > flush > stall > normal advance.
// -----------------------------------------------------------------------------
module instr_decode
    import mips_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    instr_decode_if.slave bus
);

    if_id_t      ifid_q, ifid_d;
    id_ex_t      idex_q, idex_d;
    id_ex_t      dec;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rt_used;
    logic        stall;

    assign opcode = ifid_q.instr[31:26];
    assign rs     = ifid_q.instr[25:21];
    assign rt     = ifid_q.instr[20:16];
    assign rd     = ifid_q.instr[15:11];
    assign imm    = ifid_q.instr[15:0];

    reg_file u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .we_i      (bus.wb_en),
        .waddr_i   (bus.wb_addr),
        .wdata_i   (bus.wb_data),
        .raddr_a_i (rs),
        .rdata_a_o (rs_val),
        .raddr_b_i (rt),
        .rdata_b_o (rt_val)
    );

    // Decode of the IF/ID instruction into an ID/EX record. Control bits are
    // qualified by valid so a killed or bad instruction never writes or loads.
    always_comb begin : decode
        dec           = '0;
        dec.valid     = ifid_q.valid;
        dec.opcode    = opcode;
        dec.rs_val    = rs_val;
        dec.rt_val    = rt_val;
        dec.imm       = {{16{imm[15]}}, imm};
        dec.dest      = (opcode == OP_RTYPE) ? rd : rt;
        dec.reg_write = ifid_q.valid && writes_reg(opcode) && (dec.dest != 5'd0);
        dec.is_load   = ifid_q.valid && (opcode == OP_LW);
        dec.pc_plus_4 = ifid_q.pc_plus_4;
    end

    // Load-use hazard: the load in EX produces its value too late for the
    // instruction now in ID, so insert one bubble.
    always_comb begin : hazard
        rt_used = uses_rt(opcode);
        stall   = ifid_q.valid && idex_q.valid && idex_q.is_load
                  && (idex_q.dest != 5'd0)
                  && ((idex_q.dest == rs) || (rt_used && (idex_q.dest == rt)));
    end

    always_comb begin : next_state
        ifid_d = ifid_q;
        idex_d = '0;
        if (bus.flush) begin
            ifid_d = '0;
        end else if (stall) begin
            ifid_d = ifid_q;
        end else begin
            ifid_d.instr     = bus.if_instr;
            ifid_d.pc_plus_4 = bus.if_pc_plus_4;
            ifid_d.valid     = (bus.if_instr != BAD_INSTR);
            idex_d           = dec;
        end
    end

    always_ff @(posedge clk) begin : pipe_regs
        if (!reset) begin
            ifid_q <= '0;
            idex_q <= '0;
        end else begin
            ifid_q <= ifid_d;
            idex_q <= idex_d;
        end
    end

    always_comb begin : outputs
        bus.stall        = stall;
        bus.id_valid     = idex_q.valid;
        bus.id_opcode    = idex_q.opcode;
        bus.id_rs_val    = idex_q.rs_val;
        bus.id_rt_val    = idex_q.rt_val;
        bus.id_imm       = idex_q.imm;
        bus.id_dest      = idex_q.dest;
        bus.id_reg_write = idex_q.valid && idex_q.reg_write;
        bus.id_is_load   = idex_q.valid && idex_q.is_load;
        bus.id_pc_plus_4 = idex_q.pc_plus_4;
    end

endmodule

// File: tb/tb_instr_decode.sv
// -----------------------------------------------------------------------------
// tb_instr_decode
// Self-checking bench for instr_decode: a vector table pushed through a
// scoreboard queue, plus directed sequences for stall, flush, regfile write
// timing and reset.
// -----------------------------------------------------------------------------
module tb_instr_decode;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;

    instr_decode_if bus ();

    instr_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        Instr        instr;
        logic [31:0] pc;
        logic        valid;
        logic [5:0]  opcode;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic        rw;
        logic        ld;
    } vec_t;

    localparam int N = 11;
    localparam Instr NOP = 32'h0000_0000;

    vec_t vecs [N];
    vec_t sb [$];
    vec_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic Instr rtype(input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic Instr itype(input logic [5:0] op, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic vec_t mk(input Instr i, input logic v, input logic [5:0] op,
                                input logic [31:0] rsv, input logic [31:0] rtv,
                                input logic [31:0] im, input logic [4:0] d,
                                input logic rw, input logic ld);
        vec_t r;
        r.instr = i; r.pc = 32'd0; r.valid = v; r.opcode = op; r.rs_val = rsv;
        r.rt_val = rtv; r.imm = im; r.dest = d; r.rw = rw; r.ld = ld;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input Instr i, input logic [31:0] pc);
        bus.if_instr     = i;
        bus.if_pc_plus_4 = pc;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        bus.wb_en   = en;
        bus.wb_addr = a;
        bus.wb_data = d;
    endtask

    task automatic chk_id(input string tag, input vec_t x);
        chk({tag, ".valid"}, 32'(bus.id_valid), 32'(x.valid));
        chk({tag, ".reg_write"}, 32'(bus.id_reg_write), 32'(x.rw));
        chk({tag, ".is_load"}, 32'(bus.id_is_load), 32'(x.ld));
        if (x.valid) begin
            chk({tag, ".opcode"}, 32'(bus.id_opcode), 32'(x.opcode));
            chk({tag, ".rs_val"}, bus.id_rs_val, x.rs_val);
            chk({tag, ".rt_val"}, bus.id_rt_val, x.rt_val);
            chk({tag, ".imm"}, bus.id_imm, x.imm);
            chk({tag, ".dest"}, 32'(bus.id_dest), 32'(x.dest));
            chk({tag, ".pc"}, bus.id_pc_plus_4, x.pc);
        end
    endtask

    // Drives LW r4,8(r1) then ADD r6,r4,r2; returns with the load in ID/EX.
    task automatic load_use_pair();
        drive(itype(OP_LW, 5'd1, 5'd4, 16'd8), 32'h200);
        step();
        chk("lu.pre_stall", 32'(bus.stall), 0);
        drive(rtype(5'd4, 5'd2, 5'd6), 32'h204);
        step();
        chk("lu.stall", 32'(bus.stall), 1);
        chk("lu.ld_opcode", 32'(bus.id_opcode), 32'(OP_LW));
        chk("lu.ld_is_load", 32'(bus.id_is_load), 1);
        chk("lu.ld_rs_val", bus.id_rs_val, 32'h1111_1111);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random fetch traffic.
        reset = 1'b0;
        bus.flush = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        drive($urandom, $urandom);
        step();
        drive($urandom, $urandom);
        step();
        chk("rst.valid", 32'(bus.id_valid), 0);
        chk("rst.opcode", 32'(bus.id_opcode), 0);
        chk("rst.rs_val", bus.id_rs_val, 0);
        chk("rst.rt_val", bus.id_rt_val, 0);
        chk("rst.imm", bus.id_imm, 0);
        chk("rst.dest", 32'(bus.id_dest), 0);
        chk("rst.reg_write", 32'(bus.id_reg_write), 0);
        chk("rst.is_load", 32'(bus.id_is_load), 0);
        chk("rst.pc", bus.id_pc_plus_4, 0);
        chk("rst.stall", 32'(bus.stall), 0);

        // Preload registers through the writeback port.
        reset = 1'b1;
        drive(NOP, 32'd0);
        wb(1'b1, 5'd1, 32'h1111_1111); step();
        wb(1'b1, 5'd2, 32'h2222_2222); step();
        wb(1'b1, 5'd5, 32'h1234_5678); step();
        wb(1'b1, 5'd9, 32'hDEAD_BEEF); step();
        wb(1'b1, 5'd7, 32'h0000_0033); step();
        wb(1'b0, 5'd0, 32'd0);         step();

        vecs[0]  = mk(rtype(5'd5, 5'd0, 5'd3), 1, OP_RTYPE, 32'h1234_5678, 32'h0,
                      32'h0000_1820, 5'd3, 1, 0);
        vecs[1]  = mk(itype(6'h08, 5'd1, 5'd4, 16'hFFFF), 1, 6'h08, 32'h1111_1111, 32'h0,
                      32'hFFFF_FFFF, 5'd4, 1, 0);
        vecs[2]  = mk(itype(OP_SW, 5'd9, 5'd2, 16'h0004), 1, OP_SW, 32'hDEAD_BEEF,
                      32'h2222_2222, 32'h0000_0004, 5'd2, 0, 0);
        vecs[3]  = mk(itype(OP_BEQ, 5'd1, 5'd2, 16'h8000), 1, OP_BEQ, 32'h1111_1111,
                      32'h2222_2222, 32'hFFFF_8000, 5'd2, 0, 0);
        vecs[4]  = mk(itype(OP_LW, 5'd1, 5'd0, 16'h0000), 1, OP_LW, 32'h1111_1111, 32'h0,
                      32'h0, 5'd0, 0, 1);
        vecs[5]  = mk(itype(OP_LW, 5'd2, 5'd10, 16'h7FFF), 1, OP_LW, 32'h2222_2222, 32'h0,
                      32'h0000_7FFF, 5'd10, 1, 1);
        // Load to r23 precedes BAD_INSTR, whose rs field is 23.
        vecs[6]  = mk(itype(OP_LW, 5'd1, 5'd23, 16'h0000), 1, OP_LW, 32'h1111_1111, 32'h0,
                      32'h0, 5'd23, 1, 1);
        vecs[7]  = mk(BAD_INSTR, 0, 6'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0);
        vecs[8]  = mk(itype(6'h0D, 5'd9, 5'd11, 16'hABCD), 1, 6'h0D, 32'hDEAD_BEEF, 32'h0,
                      32'hFFFF_ABCD, 5'd11, 1, 0);
        vecs[9]  = mk(itype(OP_BNE, 5'd5, 5'd3, 16'h0010), 1, OP_BNE, 32'h1234_5678, 32'h0,
                      32'h0000_0010, 5'd3, 0, 0);
        vecs[10] = mk(rtype(5'd1, 5'd2, 5'd0), 1, OP_RTYPE, 32'h1111_1111, 32'h2222_2222,
                      32'h0000_0020, 5'd0, 0, 0);

        for (int i = 0; i <= N; i++) begin
            if (i < N) begin
                vecs[i].pc = 32'h1000 + 32'(4 * i);
                drive(vecs[i].instr, vecs[i].pc);
                sb.push_back(vecs[i]);
            end else begin
                drive(NOP, 32'd0);
            end
            step();
            chk($sformatf("tbl%0d.stall", i), 32'(bus.stall), 0);
            if (sb.size() == 2 || (i == N && sb.size() > 0)) begin
                e = sb.pop_front();
                chk_id($sformatf("vec%0d", i - 1), e);
            end
        end
        chk("tbl.sb_empty", 32'(sb.size()), 0);

        // Load-use: one stall cycle, one bubble, then the ADD issues.
        load_use_pair();
        drive(NOP, 32'h208);
        step();
        chk("lu.bubble_stall", 32'(bus.stall), 0);
        chk("lu.bubble_valid", 32'(bus.id_valid), 0);
        chk("lu.bubble_rw", 32'(bus.id_reg_write), 0);
        chk("lu.bubble_ld", 32'(bus.id_is_load), 0);
        step();
        chk("lu.add_valid", 32'(bus.id_valid), 1);
        chk("lu.add_dest", 32'(bus.id_dest), 6);
        chk("lu.add_rw", 32'(bus.id_reg_write), 1);
        chk("lu.add_rt_val", bus.id_rt_val, 32'h2222_2222);
        chk("lu.add_pc", bus.id_pc_plus_4, 32'h204);
        chk("lu.add_stall", 32'(bus.stall), 0);

        // Flush while stalled.
        load_use_pair();
        drive(NOP, 32'h208);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("fl.valid", 32'(bus.id_valid), 0);
        chk("fl.stall", 32'(bus.stall), 0);
        chk("fl.rw", 32'(bus.id_reg_write), 0);
        chk("fl.ld", 32'(bus.id_is_load), 0);
        step();
        chk("fl.killed_valid", 32'(bus.id_valid), 0);
        step();
        chk("fl.recover_valid", 32'(bus.id_valid), 1);

        // Writeback in the same cycle as decode of ADD r8,r7,r0.
        drive(rtype(5'd7, 5'd0, 5'd8), 32'h300);
        step();
        drive(NOP, 32'h304);
        wb(1'b1, 5'd7, 32'h0000_00A5);
        step();
        wb(1'b0, 5'd0, 32'd0);
`ifdef REGFILE_BYPASS_EN
        chk("byp.same_cycle", bus.id_rs_val, 32'h0000_00A5);
`else
        chk("byp.same_cycle", bus.id_rs_val, 32'h0000_0033);
`endif
        drive(rtype(5'd7, 5'd0, 5'd8), 32'h308);
        step();
        drive(NOP, 32'h30C);
        step();
        chk("byp.later", bus.id_rs_val, 32'h0000_00A5);

        // Writes to r0 never become visible.
        drive(rtype(5'd0, 5'd0, 5'd8), 32'h310);
        step();
        drive(NOP, 32'h314);
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        step();
        wb(1'b0, 5'd0, 32'd0);
        chk("r0.same_rs", bus.id_rs_val, 0);
        chk("r0.same_rt", bus.id_rt_val, 0);
        drive(rtype(5'd0, 5'd0, 5'd8), 32'h318);
        step();
        drive(NOP, 32'h31C);
        step();
        chk("r0.later_rs", bus.id_rs_val, 0);

        // Reset mid-stall beats a concurrent writeback.
        load_use_pair();
        reset = 1'b0;
        wb(1'b1, 5'd9, 32'h5555_5555);
        drive(NOP, 32'h208);
        step();
        chk("rst2.valid", 32'(bus.id_valid), 0);
        chk("rst2.opcode", 32'(bus.id_opcode), 0);
        chk("rst2.rs_val", bus.id_rs_val, 0);
        chk("rst2.dest", 32'(bus.id_dest), 0);
        chk("rst2.pc", bus.id_pc_plus_4, 0);
        chk("rst2.stall", 32'(bus.stall), 0);
        reset = 1'b1;
        wb(1'b0, 5'd0, 32'd0);
        drive(rtype(5'd5, 5'd9, 5'd1), 32'h400);
        step();
        drive(NOP, 32'h404);
        step();
        chk("rst2.add_valid", 32'(bus.id_valid), 1);
        chk("rst2.r5_cleared", bus.id_rs_val, 0);
        chk("rst2.r9_cleared", bus.id_rt_val, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have port: clk  input  1  single pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset; sampled on clk rising edge only.
REQ-003 SHALL have port: if_instr  input  instr_width  instruction from fetch stage.
REQ-004 SHALL have port: if_pc_plus_4  input  adddr_width  fetch PC+4 paired with if_instr.
REQ-005 SHALL have port: flush  input  1  branch taken in EX; kill younger instructions.
REQ-006 SHALL have ports: wb_en  input  1; wb_addr  input  5; wb_data  input  32  register-file write port.
REQ-007 SHALL have port: stall  output  1  hold fetch PC and IF/ID this cycle.
REQ-008 SHALL have ports (ID/EX register outputs): id_valid 1; id_opcode 6; id_rs_val 32; id_rt_val 32; id_imm 32 (sign-extended); id_dest 5; id_reg_write 1; id_is_load 1; id_pc_plus_4 adddr_width.

Function
REQ-009 SHALL contain an IF/ID register (instr, pc_plus_4, valid) and an ID/EX register driving all id_* outputs.
REQ-010 SHALL decode fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
REQ-011 SHALL produce dest = rd for OP_RTYPE, else rt; reg_write = 1 for OP_RTYPE, OP_LW and ALU-immediate opcodes, 0 for OP_SW/OP_BEQ/OP_BNE; reg_write forced 0 when dest = 0.
REQ-012 SHALL treat rt as a source for OP_RTYPE, OP_SW, OP_BEQ, OP_BNE; rs always a source.
REQ-013 SHALL sign-extend imm[15] into id_imm[31:16].
REQ-014 SHALL implement a 32x32 register file; register 0 reads 0 always; writes to 0 ignored.
REQ-015 SHALL write wb_data to wb_addr on clk edge when wb_en = 1.
REQ-016 SHALL capture a fetched instruction with valid = 0 when if_instr == BAD_INSTR (32'hFEEDDEAD).
REQ-017 SHALL assert stall combinationally when IF/ID valid, ID/EX valid, id_is_load = 1, id_dest != 0, and id_dest matches a used source of the IF/ID instruction.
REQ-018 SHALL, while stall = 1 and flush = 0: hold IF/ID unchanged and load a bubble (id_valid = 0, id_reg_write = 0, id_is_load = 0) into ID/EX.
REQ-019 SHALL, when flush = 1: load IF/ID valid = 0 and ID/EX bubble on the next edge; flush overrides stall.
REQ-020 SHALL, with no stall/flush, advance: if_* -> IF/ID, decoded IF/ID -> ID/EX each edge; latency from if_instr to id_* = 2 edges.
REQ-021 SHALL force all ID/EX control outputs (id_reg_write, id_is_load) to 0 whenever id_valid = 0.

Reset
REQ-022 SHALL, when reset = 0 at an edge, clear IF/ID and ID/EX to all-zero (id_valid = 0, all id_* = 0); stall then reads 0.
REQ-023 SHALL clear all 32 register-file entries to 0 on reset.
REQ-024 SHALL give reset priority over flush, stall and wb_en, including mid-stall.

Configuration
REQ-025 SHALL support macro REGFILE_BYPASS_EN: defined -> a read of wb_addr while wb_en = 1 (wb_addr != 0) returns wb_data in the same cycle; undefined -> read returns the pre-write value (write-then-read takes one extra cycle).

Structure
REQ-026 SHALL place OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, BAD_INSTR, and an id_ex_t packed struct for the ID/EX register in mips_pkg, alongside the existing instr_width, adddr_width and Instr.
REQ-027 SHALL implement the register file as one sub-module, reg_file (2 read ports, 1 write port, bypass under REGFILE_BYPASS_EN).

Verification
REQ-028 SHALL cover: reset = 0 for 2 cycles with if_instr random -> all id_* = 0, stall = 0.
REQ-029 SHALL cover: wb r5 = 0x12345678, then ADD r3,r5,r0 -> after 2 edges id_rs_val = 0x12345678, id_dest = 3, id_reg_write = 1.
REQ-030 SHALL cover: LW r4,8(r1) followed by ADD r6,r4,r2 -> stall = 1 for exactly 1 cycle, one bubble (id_valid = 0), then ADD issues.
REQ-031 SHALL cover: flush = 1 together with stall = 1 -> next cycle id_valid = 0, IF/ID valid = 0, stall = 0.
REQ-032 SHALL cover: if_instr = 32'hFEEDDEAD -> 2 edges later id_valid = 0, no stall triggered.
REQ-033 SHALL cover: wb_en to r7 = 0xA5 same cycle as decoding ADD r8,r7,r0 -> id_rs_val = 0xA5 with REGFILE_BYPASS_EN, old value without; writes to r0 read back 0.
